// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STATS_CNT_W = 16;
  localparam logic [STATS_CNT_W-1:0] STATS_CNT_MAX = '1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   pick
);

  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W:0]       sum;

  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];
  assign any     = |req;

  // Walk offsets from the far end so the smallest offset from ptr wins.
  always_comb begin
    pick = '0;
    sum  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(j);
        if (sum >= NUM_L) sum = sum - NUM_L;
        pick = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// N-to-1 burst write arbiter in front of a FIFO with round-robin grants.
// Optional per-requester beat counters are enabled with FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              reqValid,
  input  logic [NUM_REQ-1:0]              reqLast,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   reqData,
  output logic [NUM_REQ-1:0]              reqReady,
  input  logic [$clog2(FIFO_DEPTH):0]     fifoDataCount,
  output logic                            fifoWrEn,
  output logic [FIFO_WIDTH-1:0]           fifoWrData,
  output logic [$clog2(NUM_REQ)-1:0]      grantId,
  output logic                            grantActive
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0]  arbBeatCnt
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W:0]    DEPTH_L   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;
  logic                    grant_active_q, grant_active_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic [FIFO_WIDTH-1:0]   data_arr [NUM_REQ];
  logic [FIFO_WIDTH-1:0]   cur_data;
  logic                    cur_valid;
  logic                    cur_last;
  logic [CNT_W:0]          occ_next;
  logic                    space_ok;
  logic                    accept;
  logic                    burst_done;
  logic                    pick_any;
  logic [IDX_W-1:0]        pick_id;
  logic [IDX_W-1:0]        next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req  (reqValid),
    .ptr  (rr_ptr_q),
    .any  (pick_any),
    .pick (pick_id)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = reqData[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign cur_data  = data_arr[grant_id_q];
  assign cur_valid = reqValid[grant_id_q];
  assign cur_last  = reqLast[grant_id_q];

  // The beat still in the write register counts toward occupancy so
  // back-to-back accepts never push the FIFO past its depth.
  assign occ_next = {1'b0, fifoDataCount} + {{CNT_W{1'b0}}, wr_en_q};
  assign space_ok = occ_next < DEPTH_L;

  always_comb begin
    reqReady             = '0;
    reqReady[grant_id_q] = grant_active_q & space_ok;
  end

  assign accept     = grant_active_q & cur_valid & space_ok;
  assign burst_done = accept & (cur_last | (beat_cnt_q == LAST_BEAT));
  assign next_ptr   = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    wr_en_d        = accept;
    wr_data_d      = accept ? cur_data : wr_data_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d        = BURST;
          grant_id_d     = pick_id;
          grant_active_d = 1'b1;
          beat_cnt_d     = '0;
        end
      end
      BURST: begin
        // A stalled or idle grantee keeps the grant; only a finished burst releases it.
        if (burst_done) begin
          state_d        = IDLE;
          grant_active_d = 1'b0;
          beat_cnt_d     = '0;
          rr_ptr_d       = next_ptr;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d        = IDLE;
        grant_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign fifoWrEn    = wr_en_q;
  assign fifoWrData  = wr_data_q;
  assign grantId     = grant_id_q;
  assign grantActive = grant_active_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] stat_q [NUM_REQ];
  logic [STATS_CNT_W-1:0] stat_d [NUM_REQ];

  function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
    return (v == STATS_CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    arbBeatCnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (accept && (grant_id_q == IDX_W'(i))) stat_d[i] = sat_inc(stat_q[i]);
      arbBeatCnt[i*STATS_CNT_W +: STATS_CNT_W] = stat_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst sequencing, round-robin order, backpressure, reset abort.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   reqValid;
  logic [NR-1:0]   reqLast;
  logic [NR*W-1:0] reqData;
  logic [NR-1:0]   reqReady;
  logic [3:0]      fifoDataCount;
  logic            fifoWrEn;
  logic [W-1:0]    fifoWrData;
  logic [1:0]      grantId;
  logic            grantActive;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] arbBeatCnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reqValid      (reqValid),
    .reqLast       (reqLast),
    .reqData       (reqData),
    .reqReady      (reqReady),
    .fifoDataCount (fifoDataCount),
    .fifoWrEn      (fifoWrEn),
    .fifoWrData    (fifoWrData),
    .grantId       (grantId),
    .grantActive   (grantActive)
`ifdef FIFO_ARB_STATS_EN
    ,
    .arbBeatCnt    (arbBeatCnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rq = 0;

  logic [7:0] src_data [NR][16];
  logic       src_last [NR][16];
  int         src_len  [NR];
  int         src_idx  [NR];

  logic [7:0] wr_q[$];
  int         wr_cyc[$];
  int         gnt_q[$];
  logic       ga_prev = 1'b0;

  int offs [8] = '{2, 3, 5, 6, 8, 9, 11, 12};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_idx[i] < src_len[i]) begin
        reqValid[i]       = 1'b1;
        reqLast[i]        = src_last[i][src_idx[i]];
        reqData[i*W +: W] = src_data[i][src_idx[i]];
      end else begin
        reqValid[i]       = 1'b0;
        reqLast[i]        = 1'b0;
        reqData[i*W +: W] = '0;
      end
    end
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base, input bit last);
    for (int j = 0; j < n; j++) begin
      src_data[i][j] = base + 8'(j);
      src_last[i][j] = last && (j == n - 1);
    end
    src_len[i] = n;
    src_idx[i] = 0;
    drive();
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc.delete();
    gnt_q.delete();
  endtask

  // Observe on the falling edge, then advance sources for beats taken at the rising edge.
  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    if (fifoWrEn) begin
      wr_q.push_back(fifoWrData);
      wr_cyc.push_back(cyc);
    end
    if (grantActive && !ga_prev) gnt_q.push_back(int'(grantId));
    ga_prev = grantActive;
    acc = reqValid & reqReady;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (acc[i]) src_idx[i]++;
    drive();
  endtask

  task automatic expect_writes(input string tag, input logic [63:0] exp, input int n);
    check_val({tag, "_count"}, 32'(wr_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      check_val($sformatf("%s_%0d", tag, k),
                (k < wr_q.size()) ? 32'(wr_q[k]) : 32'hFFFF_FFFF, 32'(exp[k*8 +: 8]));
  endtask

  task automatic expect_grants(input string tag, input logic [31:0] exp, input int n);
    check_val({tag, "_count"}, 32'(gnt_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      check_val($sformatf("%s_%0d", tag, k),
                (k < gnt_q.size()) ? 32'(gnt_q[k]) : 32'hFFFF_FFFF, 32'(exp[k*4 +: 4]));
  endtask

  initial begin
    reqValid = '0;
    reqLast = '0;
    reqData = '0;
    fifoDataCount = '0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    check_val("rst_grantActive", 32'(grantActive), 32'h0);
    check_val("rst_grantId", 32'(grantId), 32'h0);
    check_val("rst_fifoWrEn", 32'(fifoWrEn), 32'h0);
    check_val("rst_fifoWrData", 32'(fifoWrData), 32'h0);
    check_val("rst_reqReady", 32'(reqReady), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single requester, three-beat packet.
    clear_logs();
    load(0, 3, 8'hA1, 1'b1);
    rq = cyc;
    tick();
    check_val("s1_grantActive", 32'(grantActive), 32'h1);
    check_val("s1_grantId", 32'(grantId), 32'h0);
    check_val("s1_reqReady", 32'(reqReady), 32'h1);
    repeat (6) tick();
    expect_writes("s1_wr", 64'h0000_0000_00A3_A2A1, 3);
    check_val("s1_lat_first", (wr_cyc.size() > 0) ? 32'(wr_cyc[0] - rq) : 32'hFFFF_FFFF, 32'd2);
    check_val("s1_lat_last", (wr_cyc.size() > 2) ? 32'(wr_cyc[2] - rq) : 32'hFFFF_FFFF, 32'd4);
    check_val("s1_idle", 32'(grantActive), 32'h0);

    // Pointer now at 1: requester 1 goes before requester 0.
    clear_logs();
    load(0, 1, 8'hB0, 1'b1);
    load(1, 1, 8'hB1, 1'b1);
    repeat (8) tick();
    expect_grants("s2_gnt", 32'h01, 2);
    expect_writes("s2_wr", 64'h0000_0000_0000_B0B1, 2);

    // Reset pulse restarts arbitration at requester 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // All four requesting, two-beat packets each.
    clear_logs();
    load(0, 2, 8'h10, 1'b1);
    load(1, 2, 8'h20, 1'b1);
    load(2, 2, 8'h30, 1'b1);
    load(3, 2, 8'h40, 1'b1);
    rq = cyc;
    repeat (14) tick();
    expect_grants("s3_gnt", 32'h3210, 4);
    expect_writes("s3_wr", 64'h4140_3130_2120_1110, 8);
    for (int k = 0; k < 8; k++)
      check_val($sformatf("s3_cyc_%0d", k),
                (k < wr_cyc.size()) ? 32'(wr_cyc[k] - rq) : 32'hFFFF_FFFF, 32'(offs[k]));

    // Six beats without last from requester 2 are split at MAX_BURST.
    clear_logs();
    load(2, 6, 8'h50, 1'b0);
    load(3, 1, 8'h60, 1'b1);
    repeat (14) tick();
    expect_grants("s4_gnt", 32'h232, 3);
    expect_writes("s4_wr", 64'h0055_5460_5352_5150, 7);
    check_val("s4_held_active", 32'(grantActive), 32'h1);
    check_val("s4_held_id", 32'(grantId), 32'h2);

    // Grantee has no beat: grant held, other requester ignored.
    clear_logs();
    load(0, 1, 8'h70, 1'b1);
    repeat (4) tick();
    check_val("s4_hold_nowr", 32'(wr_q.size()), 32'h0);
    check_val("s4_hold_id", 32'(grantId), 32'h2);
    check_val("s4_hold_ready", 32'(reqReady), 32'h4);
    clear_logs();
    load(2, 1, 8'h56, 1'b1);
    repeat (8) tick();
    expect_writes("s4_resume_wr", 64'h0000_0000_0000_7056, 2);
    expect_grants("s4_resume_gnt", 32'h0, 1);

    // FIFO nearly full: one beat fits, then stall until space returns.
    clear_logs();
    fifoDataCount = 4'd7;
    load(1, 3, 8'h80, 1'b1);
    tick();
    check_val("s5_ready_first", 32'(reqReady), 32'h2);
    tick();
    check_val("s5_wren", 32'(fifoWrEn), 32'h1);
    check_val("s5_ready_full", 32'(reqReady), 32'h0);
    fifoDataCount = 4'd8;
    repeat (3) tick();
    check_val("s5_stall_wr", 32'(wr_q.size()), 32'h1);
    check_val("s5_stall_ready", 32'(reqReady), 32'h0);
    fifoDataCount = 4'd5;
    repeat (6) tick();
    expect_writes("s5_wr", 64'h0000_0000_0082_8180, 3);

    // Reset in the middle of a burst.
    fifoDataCount = 4'd0;
    clear_logs();
    load(2, 4, 8'h90, 1'b1);
    tick();
    tick();
    check_val("s6_pre_wren", 32'(fifoWrEn), 32'h1);
    check_val("s6_pre_data", 32'(fifoWrData), 32'h90);
    #2 reset = 1'b1;
    #1;
    check_val("s6_rst_wren", 32'(fifoWrEn), 32'h0);
    check_val("s6_rst_data", 32'(fifoWrData), 32'h0);
    check_val("s6_rst_active", 32'(grantActive), 32'h0);
    check_val("s6_rst_id", 32'(grantId), 32'h0);
    check_val("s6_rst_ready", 32'(reqReady), 32'h0);
    src_len[2] = 0;
    drive();
    clear_logs();
    tick();
    reset = 1'b0;
    check_val("s6_rst_nowr", 32'(wr_q.size()), 32'h0);
    load(3, 1, 8'hA0, 1'b1);
    repeat (5) tick();
    expect_grants("s6_gnt", 32'h3, 1);
    expect_writes("s6_wr", 64'h0000_0000_0000_00A0, 1);

`ifdef FIFO_ARB_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_logs();
    load(1, 5, 8'hC0, 1'b1);
    repeat (14) tick();
    check_val("st_req0", 32'(arbBeatCnt[15:0]), 32'd0);
    check_val("st_req1", 32'(arbBeatCnt[31:16]), 32'd5);
    check_val("st_req2", 32'(arbBeatCnt[47:32]), 32'd0);
    check_val("st_req3", 32'(arbBeatCnt[63:48]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8: data width per beat.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: capacity of the downstream FIFO.
REQ-004 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, >=1.
REQ-005 SHALL have ports (name  direction  width  meaning):
 clk  in  1  single clock; all state on rising edge.
 reset  in  1  asynchronous, active-high reset.
 reqValid  in  NUM_REQ  per-requester beat valid.
 reqLast  in  NUM_REQ  per-requester last beat of packet.
 reqData  in  NUM_REQ*FIFO_WIDTH  packed beats; requester i at [i*FIFO_WIDTH +: FIFO_WIDTH].
 reqReady  out  NUM_REQ  per-requester beat accept.
 fifoDataCount  in  $clog2(FIFO_DEPTH)+1  downstream FIFO occupancy.
 fifoWrEn  out  1  write strobe to the FIFO.
 fifoWrData  out  FIFO_WIDTH  write data to the FIFO.
 grantId  out  $clog2(NUM_REQ)  current grantee index.
 grantActive  out  1  high while in BURST.

Function
REQ-006 SHALL implement an FSM with two states: IDLE and BURST.
REQ-007 In IDLE with any reqValid bit high, SHALL select the first requester at or after rrPtr, wrapping modulo NUM_REQ; grantId and grantActive SHALL register on the next edge.
REQ-008 A beat SHALL be accepted when reqValid[g] && reqReady[g], where g = grantId.
REQ-009 reqReady[g] SHALL be combinational: grantActive && (fifoDataCount + fifoWrEn) < FIFO_DEPTH. All other reqReady bits SHALL be 0.
REQ-010 An accepted beat SHALL appear as fifoWrEn=1, fifoWrData=beat on the next cycle (latency 1); fifoWrEn SHALL be 0 in every other cycle.
REQ-011 A beat counter SHALL increment per accepted beat. BURST SHALL end on the edge after accepting a beat with reqLast[g]=1 or the MAX_BURST-th beat.
REQ-012 On burst end, SHALL go to IDLE, clear the beat counter, and set rrPtr = (g+1) mod NUM_REQ. The mandatory IDLE cycle is the single arbitration bubble.
REQ-013 If reqValid[g] drops mid-burst, the grant SHALL be held and no other requester served.
REQ-014 If the FIFO is full, SHALL stall in BURST with no beat lost or duplicated.
REQ-015 Minimum request-to-write latency SHALL be 2 cycles: request at t, grant at t+1, fifoWrEn at t+2.
REQ-016 With FIFO_DEPTH=8, occupancy SHALL never exceed 8, including back-to-back accepts.

Reset
REQ-017 Reset assertion SHALL immediately force the following, independent of clk: state=IDLE, rrPtr=0, beat counter=0, grantId=0, grantActive=0, fifoWrEn=0, fifoWrData=0, reqReady=0.
REQ-018 Reset asserted mid-burst SHALL abort the burst; the beat registered in that cycle SHALL NOT be written.
REQ-019 After reset deassertion, arbitration SHALL start from requester 0.

Configuration
REQ-020 Macro FIFO_ARB_STATS_EN defined: SHALL add output arbBeatCnt, NUM_REQ*16 bits, holding per-requester accepted-beat counters. Each counter SHALL saturate at 16'hFFFF and reset to 0.
REQ-021 FIFO_ARB_STATS_EN undefined: port and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 A shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the STATS_CNT_W=16 constant.
REQ-023 One sub-module, rr_pick, SHALL hold the combinational first-set-at-or-after-pointer search, parameterised by NUM_REQ.

Verification
REQ-024 Single requester: reqValid=4'b0001, 3 beats A1,A2,A3, reqLast on A3 -> fifoWrEn on 3 consecutive cycles starting 2 cycles after request, then IDLE, rrPtr=1.
REQ-025 All four requesting, each with a 2-beat packet -> grant order 0,1,2,3, one IDLE cycle between bursts, 8 writes in order.
REQ-026 Requester 2 sends 6 beats, no reqLast, MAX_BURST=4 -> 4 beats written, grant released; requester 3 served next; remaining 2 beats after wrap.
REQ-027 fifoDataCount=7 with fifoWrEn=1 -> reqReady=0; stall until count drops; no overflow; data order preserved.
REQ-028 Reset pulse while in BURST on beat 2 -> all outputs 0 asynchronously; after release, a request from requester 3 is granted as the first set bit at or after rrPtr=0.
REQ-029 With FIFO_ARB_STATS_EN: 5 beats from requester 1 -> arbBeatCnt[31:16]=5, all other counters 0.
